ram_table: RTL and testbench
============================

# ram_table

Parametrised, writable successor of the fixed 16-entry decode table. After reset it self-loads the standard 16-value default table into a DEPTH-entry synchronous memory, then serves registered single-cycle reads and accepts run-time overwrites. It sits between the address generator and the datapath wherever the old decode table was used, and adds `busy`/`rd_valid` so consumers know when the data is valid.

## Interface
- `ADDR_W`, 4: address width; DEPTH = 2**ADDR_W entries, ADDR_W ≥ 2.
- `DATA_W`, 8: entry width; DATA_W ≥ 8.
- `clk`  in  1  single clock, all state on rising edge.
- `rst_n`  in  1  reset, asynchronous, active-low.
- `rd_en`  in  1  read request, sampled only when `busy`=0.
- `rd_addr`  in  ADDR_W  read address.
- `rd_data`  out  DATA_W  registered read data, holds last value between reads.
- `rd_valid`  out  1  one-cycle pulse, `rd_data` updated this cycle.
- `wr_en`  in  1  write request, sampled only when `busy`=0.
- `wr_addr`  in  ADDR_W  write address.
- `wr_data`  in  DATA_W  write data.
- `busy`  out  1  high while the default table is being loaded.

## Operation
- Default table, DT[0..15] = 0x03, 0x08, 0x0D, 0x14, 0x19, 0x1E, 0x25, 0x2A, 0x2C, 0x31, 0x36, 0x3D, 0x46, 0x50, 0x59, 0x6C.
- Default content of entry i = DT[i mod 16], zero-extended to DATA_W.
- FSM states: INIT and READY.
  - Reset enters INIT, with the init counter at 0.
- INIT behaviour:
  - Each cycle writes the default value for the counter address, then increments the counter.
  - Leaves for READY on the cycle that writes address DEPTH-1.
  - The counter wraps to 0 and is not used in READY.
- READY behaviour:
  - `rd_en`=1 loads mem[rd_addr] into `rd_data` and pulses `rd_valid`.
  - `wr_en`=1 writes `wr_data` to mem[wr_addr].
- `rd_en`/`wr_en` asserted while `busy`=1 are dropped silently. No queuing, no `rd_valid`.
- Read and write to the same address in the same cycle is write-first: `rd_data` returns the new `wr_data`.
- Simultaneous read and write to different addresses: both are performed.
- `rd_en`=0: `rd_data` holds its value and `rd_valid`=0.
- Reset mid-operation: outputs return to reset values immediately and INIT restarts at address 0. All run-time writes are lost.
- Reset values: `rd_data`=0, `rd_valid`=0, `busy`=1 (asserted asynchronously with `rst_n` low).

## Timing
- Load time: `busy` is high for exactly DEPTH cycles after the first rising edge with `rst_n`=1. It deasserts in the cycle after the write to address DEPTH-1.
- First accepted request: the first edge with `busy`=0.
- Read latency: 1 cycle. A request at edge N gives `rd_data` and `rd_valid` valid after edge N, until edge N+1.
- Write latency: 1 cycle. A read at edge N+1 of a location written at edge N returns the new data.
- Throughput: one read plus one write per cycle, with no bubbles.

## Structure
- Shared package `ram_pkg`:
  - `DT` constant array, 16×8.
  - Function `default_entry(addr, DATA_W)`.
  - State enum `ram_table_state_t` {INIT, READY}.
- One sub-module, `ram_table_mem`: plain 1W1R synchronous array, DEPTH×DATA_W, no reset.
- The top contains the FSM, init counter, write mux (init vs user), write-first bypass, and output registers.

## Test plan
- Reset, then wait with ADDR_W=4. `busy`=1 for 16 cycles then 0, and `rd_data`=0 throughout. Reads of 0..15 return 0x03…0x6C in order, each with a one-cycle `rd_valid`.
- ADDR_W=5, DATA_W=12. Read of address 17 returns 0x008 and address 31 returns 0x06C. `busy` lasts 32 cycles.
- Write 0xA5 to address 6, then read address 6 on the next cycle. Returns 0xA5. Address 7 still reads 0x2A.
- Same-cycle write of 0x11 to address 3 with a read of address 3. `rd_data`=0x11. A different-address pair (write 9, read 2) gives `rd_data`=0x0D and address 9 updated.
- `rd_en`/`wr_en` pulsed during INIT (write 0xFF to address 0). No `rd_valid`. After `busy` falls, address 0 reads 0x03.
- After writing 0xEE to address 5, assert `rst_n`=0 mid-stream. `busy`=1, `rd_data`=0 and `rd_valid`=0 immediately. After the reload, address 5 reads 0x1E.

Source files
------------

// File: rtl/ram_pkg.sv
// Shared definitions for ram_table: the 16-value default decode table,
// the default-content helper, and the two-state load/serve FSM encoding.
package ram_pkg;

  // Standard decode table; entry i of a DEPTH-entry memory defaults to DT[i mod 16].
  localparam logic [7:0] DT [16] = '{
    8'h03, 8'h08, 8'h0D, 8'h14, 8'h19, 8'h1E, 8'h25, 8'h2A,
    8'h2C, 8'h31, 8'h36, 8'h3D, 8'h46, 8'h50, 8'h59, 8'h6C
  };

  typedef enum logic {
    INIT  = 1'b0,
    READY = 1'b1
  } ram_table_state_t;

  // Default content of an address, zero-extended and masked to data_w bits
  // (callers cast the 64-bit result down to their entry width).
  function automatic logic [63:0] default_entry(input logic [31:0] addr,
                                                input int unsigned data_w);
    logic [63:0] val;
    logic [3:0]  idx;
    idx = 4'(addr % 32'd16);
    val = {56'd0, DT[idx]};
    if (data_w < 64) val = val & ((64'd1 << data_w) - 64'd1);
    return val;
  endfunction

endpackage

// File: rtl/ram_table_mem.sv
// Plain 1W1R memory, DEPTH x DATA_W, no reset.
// Ports: clk; we/waddr/wdata synchronous write port; raddr/rdata
// combinational read port (the owning block registers the read result).
module ram_table_mem #(
  parameter int unsigned ADDR_W = 4,
  parameter int unsigned DATA_W = 8
) (
  input  logic              clk,
  input  logic              we,
  input  logic [ADDR_W-1:0] waddr,
  input  logic [DATA_W-1:0] wdata,
  input  logic [ADDR_W-1:0] raddr,
  output logic [DATA_W-1:0] rdata
);

  logic [DATA_W-1:0] mem [2**ADDR_W];

  always_ff @(posedge clk) begin
    if (we) mem[waddr] <= wdata;
  end

  assign rdata = mem[raddr];

endmodule

// File: rtl/ram_table.sv
// Writable decode table. After reset it loads the default table into a
// 2**ADDR_W-entry memory (busy high), then serves registered single-cycle
// reads and run-time writes.
// Ports: clk, rst_n (async active-low); rd_en/rd_addr -> rd_data/rd_valid
// (registered, one-cycle latency); wr_en/wr_addr/wr_data write port;
// busy high while the default table is loading. Requests while busy are dropped.
module ram_table
  import ram_pkg::*;
#(
  parameter int unsigned ADDR_W = 4,
  parameter int unsigned DATA_W = 8
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              rd_en,
  input  logic [ADDR_W-1:0] rd_addr,
  output logic [DATA_W-1:0] rd_data,
  output logic              rd_valid,
  input  logic              wr_en,
  input  logic [ADDR_W-1:0] wr_addr,
  input  logic [DATA_W-1:0] wr_data,
  output logic              busy
);

  localparam logic [ADDR_W-1:0] LAST_ADDR = '1;

  ram_table_state_t  state, state_nxt;
  logic [ADDR_W-1:0] init_cnt, init_cnt_nxt;

  logic              mem_we;
  logic [ADDR_W-1:0] mem_waddr;
  logic [DATA_W-1:0] mem_wdata;
  logic [DATA_W-1:0] mem_rdata;

  logic              rd_fire;
  logic              wr_fire;
  logic [DATA_W-1:0] rd_next;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state    <= INIT;
      init_cnt <= '0;
    end else begin
      state    <= state_nxt;
      init_cnt <= init_cnt_nxt;
    end
  end

  // Next state plus write-port mux: the loader owns the port during INIT,
  // the user write port owns it in READY.
  always_comb begin
    state_nxt    = state;
    init_cnt_nxt = init_cnt;
    mem_we       = 1'b0;
    mem_waddr    = wr_addr;
    mem_wdata    = wr_data;
    rd_fire      = 1'b0;
    wr_fire      = 1'b0;
    case (state)
      INIT: begin
        mem_we       = 1'b1;
        mem_waddr    = init_cnt;
        mem_wdata    = DATA_W'(default_entry(32'(init_cnt), DATA_W));
        init_cnt_nxt = init_cnt + 1'b1;  // wraps to 0 after the last address
        if (init_cnt == LAST_ADDR) state_nxt = READY;
      end
      READY: begin
        rd_fire = rd_en;
        wr_fire = wr_en;
        mem_we  = wr_en;
      end
      default: state_nxt = INIT;
    endcase
  end

  // Write-first: a same-cycle write to the read address is forwarded.
  always_comb begin
    rd_next = mem_rdata;
    if (wr_fire && (wr_addr == rd_addr)) rd_next = wr_data;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rd_data  <= '0;
      rd_valid <= 1'b0;
    end else begin
      rd_valid <= rd_fire;
      if (rd_fire) rd_data <= rd_next;
    end
  end

  assign busy = (state == INIT);

  ram_table_mem #(
    .ADDR_W(ADDR_W),
    .DATA_W(DATA_W)
  ) u_mem (
    .clk   (clk),
    .we    (mem_we),
    .waddr (mem_waddr),
    .wdata (mem_wdata),
    .raddr (rd_addr),
    .rdata (mem_rdata)
  );

endmodule

// File: tb/tb_ram_table.sv
module tb_ram_table;

  logic clk;
  logic rst_n;

  // Instance A: default parameters (ADDR_W=4, DATA_W=8)
  logic       a_rd_en, a_wr_en, a_rd_valid, a_busy;
  logic [3:0] a_rd_addr, a_wr_addr;
  logic [7:0] a_rd_data, a_wr_data;

  // Instance B: ADDR_W=5, DATA_W=12
  logic        b_rd_en, b_wr_en, b_rd_valid, b_busy;
  logic [4:0]  b_rd_addr, b_wr_addr;
  logic [11:0] b_rd_data, b_wr_data;

  int unsigned total;
  int unsigned bad;

  ram_table dut_a (
    .clk      (clk),
    .rst_n    (rst_n),
    .rd_en    (a_rd_en),
    .rd_addr  (a_rd_addr),
    .rd_data  (a_rd_data),
    .rd_valid (a_rd_valid),
    .wr_en    (a_wr_en),
    .wr_addr  (a_wr_addr),
    .wr_data  (a_wr_data),
    .busy     (a_busy)
  );

  ram_table #(.ADDR_W(5), .DATA_W(12)) dut_b (
    .clk      (clk),
    .rst_n    (rst_n),
    .rd_en    (b_rd_en),
    .rd_addr  (b_rd_addr),
    .rd_data  (b_rd_data),
    .rd_valid (b_rd_valid),
    .wr_en    (b_wr_en),
    .wr_addr  (b_wr_addr),
    .wr_data  (b_wr_data),
    .busy     (b_busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  // Inputs are driven just after a negedge; outputs sampled at the next negedge.
  task automatic cycle();
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic idle_inputs();
    a_rd_en = 1'b0; a_wr_en = 1'b0; a_rd_addr = '0; a_wr_addr = '0; a_wr_data = '0;
    b_rd_en = 1'b0; b_wr_en = 1'b0; b_rd_addr = '0; b_wr_addr = '0; b_wr_data = '0;
  endtask

  task automatic read_a(input logic [3:0] addr, input logic [7:0] exp, input string tag);
    a_rd_en = 1'b1; a_rd_addr = addr;
    cycle();
    a_rd_en = 1'b0;
    check({tag, "_data"}, 32'(a_rd_data), 32'(exp));
    check({tag, "_valid"}, 32'(a_rd_valid), 32'd1);
  endtask

  task automatic read_b(input logic [4:0] addr, input logic [11:0] exp, input string tag);
    b_rd_en = 1'b1; b_rd_addr = addr;
    cycle();
    b_rd_en = 1'b0;
    check({tag, "_data"}, 32'(b_rd_data), 32'(exp));
    check({tag, "_valid"}, 32'(b_rd_valid), 32'd1);
  endtask

  // Wait (bounded) for instance A to leave the load phase.
  task automatic wait_ready_a(input string tag);
    int unsigned n;
    n = 0;
    while (a_busy && n < 100) begin
      cycle();
      n++;
    end
    check({tag, "_ready_timeout"}, 32'(a_busy), 32'd0);
  endtask

  logic [7:0] dt [16];

  initial begin
    int unsigned a_edges, b_edges;
    logic        a_init_bad;

    dt = '{8'h03, 8'h08, 8'h0D, 8'h14, 8'h19, 8'h1E, 8'h25, 8'h2A,
           8'h2C, 8'h31, 8'h36, 8'h3D, 8'h46, 8'h50, 8'h59, 8'h6C};
    total = 0;
    bad   = 0;
    rst_n = 1'b0;
    idle_inputs();

    // Reset state
    repeat (3) @(negedge clk);
    check("rst_busy_a",  32'(a_busy), 32'd1);
    check("rst_data_a",  32'(a_rd_data), 32'd0);
    check("rst_valid_a", 32'(a_rd_valid), 32'd0);
    check("rst_busy_b",  32'(b_busy), 32'd1);

    // Release reset; pulse requests into A during the load phase and count
    // how many edges each instance stays busy.
    rst_n = 1'b1;
    a_edges = 0;
    b_edges = 0;
    a_init_bad = 1'b0;
    for (int unsigned i = 0; i < 40; i++) begin
      if (i < 8) begin
        a_rd_en = 1'b1; a_rd_addr = 4'd0;
        a_wr_en = 1'b1; a_wr_addr = 4'd0; a_wr_data = 8'hFF;
      end else begin
        a_rd_en = 1'b0; a_wr_en = 1'b0;
      end
      if (a_busy) a_edges++;
      if (b_busy) b_edges++;
      cycle();
      if (a_busy && (a_rd_valid !== 1'b0 || a_rd_data !== 8'h00)) a_init_bad = 1'b1;
    end
    check("init_busy_cycles_a", a_edges, 32'd16);
    check("init_busy_cycles_b", b_edges, 32'd32);
    check("init_no_output_a", 32'(a_init_bad), 32'd0);
    check("post_init_valid_a", 32'(a_rd_valid), 32'd0);

    // Default table on A, including address 0 not overwritten during INIT
    for (int unsigned i = 0; i < 16; i++) begin
      read_a(4'(i), dt[i], $sformatf("dflt_a%0d", i));
    end
    cycle();
    check("hold_valid_a", 32'(a_rd_valid), 32'd0);
    check("hold_data_a",  32'(a_rd_data), 32'h6C);

    // Wider instance: wrapped default content, zero-extended
    read_b(5'd17, 12'h008, "dflt_b17");
    read_b(5'd31, 12'h06C, "dflt_b31");
    read_b(5'd16, 12'h003, "dflt_b16");

    // Write then read next cycle
    a_wr_en = 1'b1; a_wr_addr = 4'd6; a_wr_data = 8'hA5;
    cycle();
    a_wr_en = 1'b0;
    read_a(4'd6, 8'hA5, "wr_rd_6");
    read_a(4'd7, 8'h2A, "neighbor_7");

    // Same-address write-first
    a_wr_en = 1'b1; a_wr_addr = 4'd3; a_wr_data = 8'h11;
    read_a(4'd3, 8'h11, "wfirst_3");
    a_wr_en = 1'b0;

    // Different-address read and write in one cycle
    a_wr_en = 1'b1; a_wr_addr = 4'd9; a_wr_data = 8'h77;
    read_a(4'd2, 8'h0D, "diff_rd_2");
    a_wr_en = 1'b0;
    read_a(4'd9, 8'h77, "diff_wr_9");
    read_a(4'd3, 8'h11, "wfirst_kept_3");

    // Back-to-back reads with no bubble
    a_rd_en = 1'b1; a_rd_addr = 4'd12;
    cycle();
    check("b2b_first", 32'(a_rd_data), 32'h46);
    a_rd_addr = 4'd13;
    cycle();
    check("b2b_second", 32'(a_rd_data), 32'h50);
    check("b2b_valid", 32'(a_rd_valid), 32'd1);
    a_rd_en = 1'b0;

    // Overwrite, then reset mid-stream
    a_wr_en = 1'b1; a_wr_addr = 4'd5; a_wr_data = 8'hEE;
    cycle();
    a_wr_en = 1'b0;
    a_rd_en = 1'b1; a_rd_addr = 4'd5;
    @(posedge clk);
    #1;
    check("pre_rst_data", 32'(a_rd_data), 32'hEE);
    rst_n = 1'b0;
    #1;
    check("midrst_busy",  32'(a_busy), 32'd1);
    check("midrst_data",  32'(a_rd_data), 32'd0);
    check("midrst_valid", 32'(a_rd_valid), 32'd0);
    @(negedge clk);
    idle_inputs();
    @(negedge clk);
    rst_n = 1'b1;
    cycle();
    check("reload_busy", 32'(a_busy), 32'd1);
    wait_ready_a("reload");
    read_a(4'd5, 8'h1E, "reload_5");
    read_a(4'd6, 8'h25, "reload_6");

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
